led_pattern_sequencer: RTL

AXI4-Lite master that autonomously drives the myLED peripheral's LED register with a periodic pattern (walking-one, binary count, or fixed value), reading each value back to verify it. It sits between the board-level control signals and the myLED S00_AXI slave port and replaces processor-driven LED updates in standalone designs. Bus errors and read-back mismatches are reported through a sticky flag and a saturating counter.

---
 rtl/led_seq_pkg.sv | 26 ++
 rtl/led_seq_tick_timer.sv | 40 ++++
 rtl/led_pattern_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// led_seq_pkg : FSM states, mode encodings and AXI response code for the sequencer
// Revision    : 1.0
// ============================================================================
package led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR        = 3'd1,
    ST_WR_RESP   = 3'd2,
    ST_RD_ADDR   = 3'd3,
    ST_RD_DATA   = 3'd4,
    ST_CHECK     = 3'd5,
    ST_WAIT_TICK = 3'd6
  } state_t;

  localparam logic [1:0] MODE_WALK  = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_FIXED = 2'd2;
  localparam logic [1:0] MODE_HOLD  = 2'd3;

  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage
`default_nettype wire

// File: rtl/led_seq_tick_timer.sv
`default_nettype none
// ============================================================================
// led_seq_tick_timer : counts 0..TICK_CYCLES-2 after start, done on the last count
// Revision           : 1.0
// ============================================================================
module led_seq_tick_timer #(
  parameter int unsigned TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic done
);

  localparam int unsigned   CW   = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES - 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 2);

  logic [CW-1:0] count;
  logic          active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      count  <= '0;
      active <= 1'b1;
    end else if (active && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign done = active && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// led_pattern_sequencer : AXI4-Lite master writing/verifying a periodic LED pattern
// Revision              : 1.0
// ============================================================================
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned                    C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned                    C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                    LED_WIDTH          = 8,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]  LED_REG_ADDR       = '0,
  parameter int unsigned                    TICK_CYCLES        = 100000000
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              enable,
  input  logic [1:0]                        mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     fixed_value,
  input  logic                              clr_err,
  output logic                              busy,
  output logic                              error,
  output logic [7:0]                        err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  localparam int unsigned   DW       = C_M_AXI_DATA_WIDTH;
  localparam logic [DW-1:0] LED_MASK = (LED_WIDTH >= DW) ? {DW{1'b1}}
                                                         : DW'((64'd1 << LED_WIDTH) - 64'd1);

  state_t                 state;
  logic [1:0]             mode_q;
  logic [1:0]             bresp_q;
  logic [1:0]             rresp_q;
  logic [DW-1:0]          wval;
  logic [DW-1:0]          rdata_q;
  logic [DW-1:0]          next_wval;
  logic [LED_WIDTH-1:0]   pat;
  logic [LED_WIDTH-1:0]   pat_rot;
  logic                   payload_on;
  logic                   tick_done;
  logic                   tick_start;
  logic                   tick_clear;
  logic                   start_wr;
  logic                   to_idle;
  logic                   fault;

  assign pat_rot   = (pat << 1) | (pat >> (LED_WIDTH - 1));
  assign next_wval = (mode == MODE_FIXED) ? (fixed_value & LED_MASK) : DW'(pat);
  assign fault     = (bresp_q != RESP_OKAY) || (rresp_q != RESP_OKAY) || (rdata_q != wval);

  assign start_wr   = enable && ((state == ST_IDLE) || ((state == ST_WAIT_TICK) && tick_done));
  assign to_idle    = !enable && ((state == ST_CHECK) || (state == ST_WAIT_TICK));
  assign tick_start = (state == ST_CHECK) && enable;
  assign tick_clear = (state == ST_WAIT_TICK) && (!enable || tick_done);

  assign busy         = (state != ST_IDLE);
  assign m_axi_awaddr = payload_on ? LED_REG_ADDR : '0;
  assign m_axi_araddr = payload_on ? LED_REG_ADDR : '0;
  assign m_axi_wstrb  = payload_on ? '1 : '0;
  assign m_axi_wdata  = wval;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  led_seq_tick_timer #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .start (tick_start),
    .clear (tick_clear),
    .done  (tick_done)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      payload_on    <= 1'b0;
      wval          <= '0;
      rdata_q       <= '0;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
      mode_q        <= MODE_WALK;
      pat           <= LED_WIDTH'(1);
      error         <= 1'b0;
      err_count     <= '0;
    end else begin
      if (start_wr) begin
        state         <= ST_WR;
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        payload_on    <= 1'b1;
        mode_q        <= mode;
        wval          <= next_wval;
      end else if (to_idle) begin
        state      <= ST_IDLE;
        payload_on <= 1'b0;
        wval       <= '0;
      end

      case (state)
        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          // A dropped valid means that channel's handshake already happened.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            state        <= ST_WR_RESP;
            m_axi_bready <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            bresp_q       <= m_axi_bresp;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b1;
            state         <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            rdata_q      <= m_axi_rdata;
            rresp_q      <= m_axi_rresp;
            m_axi_rready <= 1'b0;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          unique case (mode_q)
            MODE_WALK:             pat <= pat_rot;
            MODE_COUNT:            pat <= pat + 1'b1;
            MODE_FIXED, MODE_HOLD: pat <= pat;
          endcase
          if (enable) state <= ST_WAIT_TICK;
        end
        default: ;
      endcase

      // A fault in the same cycle as clr_err restarts the count at one.
      if ((state == ST_CHECK) && fault) begin
        error     <= 1'b1;
        err_count <= clr_err ? 8'd1 : ((err_count == 8'hFF) ? 8'hFF : err_count + 8'd1);
      end else if (clr_err) begin
        error     <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule
`default_nettype wire
